mips_multicycle_controller: RTL
===============================

// Module: mips_multicycle_controller
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. Decodes Op in DECODE and sequences
//  the shared ALU, memory, register file and PC across FETCH/DECODE/EXEC/MEM/WB states.
//  Drives ALUOp to the downstream ALU decoder. Stalls memory states for a fixed number
//  of cycles set by MEM_LAT.
// PARAMETERS
//  MEM_LAT  1  cycles per memory access (FETCH, MEMREAD, MEMWRITE); legal 1..15
//  STATE_W  4  width of the state register / State debug port
// PORTS
//  clk       in   1        rising-edge clock; single clock domain
//  reset     in   1        synchronous, active-high
//  Op        in   6        instruction opcode, from the instruction register
//  Zero      in   1        ALU zero flag
//  IorD      out  1        memory address select: 0=PC, 1=ALUOut
//  MemWrite  out  1        data memory write enable
//  IRWrite   out  1        instruction register load
//  RegDst    out  1        write register select: 0=rt, 1=rd
//  MemtoReg  out  1        write-back data select: 0=ALUOut, 1=Data
//  RegWrite  out  1        register file write enable
//  ALUSrcA   out  1        0=PC, 1=A
//  ALUSrcB   out  2        00=B, 01=4, 10=SignImm, 11=SignImm<<2
//  ALUOp     out  2        00=add, 01=sub, 10=use Funct, 11=unused
//  PCSrc     out  2        00=ALUResult, 01=ALUOut, 10=jump target
//  PCEn      out  1        PC load = PCWrite | (Branch & Zero)
//  Illegal   out  1        one-cycle pulse in DECODE when Op is not recognised
//  State     out  STATE_W  current state, for debug
// BEHAVIOUR
//  - Reset: on a clk edge with reset=1, state<=FETCH(0) and wcnt<=0. Takes priority over
//    everything, including mid-instruction and mid-wait. While reset=1, MemWrite, RegWrite,
//    IRWrite, PCEn and Illegal are forced to 0. All other outputs are 0 whenever
//    the current state does not assert them.
//  - Outputs are a Moore decode of the state, except PCEn, which also uses Zero.
//  - States / encodings:
//      FETCH=0    IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00;
//                 IRWrite and PCWrite asserted on the last wait cycle only.
//      DECODE=1   ALUSrcA=0, ALUSrcB=11, ALUOp=00.
//      MEMADR=2   ALUSrcA=1, ALUSrcB=10, ALUOp=00.
//      MEMRD=3    IorD=1, held for the whole wait.
//      MEMWB=4    RegDst=0, MemtoReg=1, RegWrite=1.
//      MEMWR=5    IorD=1 and MemWrite=1 on every wait cycle.
//      EXEC=6     ALUSrcA=1, ALUSrcB=00, ALUOp=10.
//      ALUWB=7    RegDst=1, MemtoReg=0, RegWrite=1.
//      BEQ=8      ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
//      ADDIEX=9   ALUSrcA=1, ALUSrcB=10, ALUOp=00.
//      ADDIWB=10  RegDst=0, MemtoReg=0, RegWrite=1.
//      JUMP=11    PCSrc=10, PCWrite=1.
//  - Transitions:
//      FETCH -> DECODE when wait is done.
//      DECODE -> by Op: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BEQ;
//                001000 -> ADDIEX; 000010 -> JUMP; any other Op -> FETCH with Illegal=1.
//      MEMADR -> MEMRD (lw) or MEMWR (sw), chosen by Op, which is held by the IR.
//      MEMRD -> MEMWB when wait is done; MEMWR -> FETCH when wait is done.
//      EXEC -> ALUWB; ADDIEX -> ADDIWB.
//      MEMWB, ALUWB, ADDIWB, BEQ, JUMP -> FETCH.
//      Encodings 12..15 -> FETCH, with no enables asserted.
//  - Wait counter wcnt (4 bit):
//      Counts only in FETCH, MEMRD and MEMWR. Wait is done when wcnt==MEM_LAT-1.
//      On done, wcnt<=0 and the state advances; otherwise wcnt increments and the state holds.
//      wcnt is 0 in every other state. With MEM_LAT=1 each memory state lasts exactly 1 cycle.
//  - Latency in cycles, where L=MEM_LAT:
//      R-type and addi: L+3.   lw: 2L+3.   sw: 2L+2.   beq and j: L+2.
//  - Branch: PCEn in BEQ equals Zero, sampled combinationally in that same cycle.
// STRUCTURE
//  - Shared package mips_ctrl_pkg holds:
//      state encodings (localparams FETCH..JUMP);
//      opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
//      ALUOp codes ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
//  - No sub-module: one state register, the wait counter, a next-state case and an output
//    case. The ALU decoder stays outside and consumes ALUOp together with Funct.
// TESTING
//  1 Reset mid-lw (in MEMRD) -> next edge State=0, wcnt=0, RegWrite=0,
//    MemWrite=0, PCEn=0 while reset=1.
//  2 MEM_LAT=1, Op=000000 -> States 0,1,6,7,0; ALUOp=10 in EXEC; RegWrite=1 and RegDst=1
//    only in ALUWB; PCEn=1 only in cycle 0.
//  3 MEM_LAT=3, Op=100011 -> FETCH 3 cycles (IRWrite=1 on the 3rd only), then 1, 2,
//    MEMRD 3 cycles with IorD=1, then MEMWB with MemtoReg=1 and RegWrite=1; total 9 cycles.
//  4 MEM_LAT=2, Op=101011 -> MEMWR 2 cycles with MemWrite=1 both cycles, then FETCH;
//    RegWrite never 1.
//  5 Op=000100 in BEQ: Zero=1 -> PCEn=1, PCSrc=01, ALUOp=01; Zero=0 -> PCEn=0.
//    Op=000010 -> JUMP with PCEn=1, PCSrc=10.
//  6 Op=111111 -> DECODE pulses Illegal=1 for 1 cycle, then FETCH; no RegWrite or
//    MemWrite. Force state=13 -> FETCH on the next edge.

Source files
------------

// File: rtl/mips_multicycle_controller_pkg.sv
// mips_ctrl_pkg: state encodings, opcodes and ALU control codes shared by the multicycle MIPS controller
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM2   = 2'b11;
  localparam logic [1:0] PC_ALU      = 2'b00;
  localparam logic [1:0] PC_ALUOUT   = 2'b01;
  localparam logic [1:0] PC_JUMP     = 2'b10;
endpackage

// File: rtl/mips_multicycle_controller_if.sv
// mips_multicycle_controller_if: opcode/flag inputs and datapath control outputs of the controller
interface mips_multicycle_controller_if #(parameter int STATE_W = 4);
  logic [5:0]         Op;
  logic               Zero;
  logic               IorD;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [1:0]         PCSrc;
  logic               PCEn;
  logic               Illegal;
  logic [STATE_W-1:0] State;
  modport master (
    input  Op, Zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
    output ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, Illegal, State
  );
  modport slave (
    output Op, Zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
    input  ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, Illegal, State
  );
endinterface

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: main control FSM sequencing the multicycle MIPS datapath with stalled memory states
module mips_multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int STATE_W = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  mips_multicycle_controller_if.master  ctl
);
  state_t     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       waits, done;
  logic       ir_w, mem_w, reg_w, pc_w, br;
  assign waits = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign done  = wcnt_q == 4'(MEM_LAT - 1);
  // state register and memory wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end
  // next state: memory states hold until the wait counter reaches MEM_LAT-1
  always_comb begin
    state_d = FETCH;
    wcnt_d  = (waits && !done) ? wcnt_q + 4'd1 : 4'd0;
    case (state_q)
      FETCH:   state_d = done ? DECODE : FETCH;
      DECODE:  state_d = (ctl.Op == OP_LW || ctl.Op == OP_SW) ? MEMADR :
                         (ctl.Op == OP_RTYPE) ? EXEC :
                         (ctl.Op == OP_BEQ)   ? BEQ :
                         (ctl.Op == OP_ADDI)  ? ADDIEX :
                         (ctl.Op == OP_J)     ? JUMP : FETCH;
      MEMADR:  state_d = (ctl.Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = done ? MEMWB : MEMRD;
      MEMWR:   state_d = done ? FETCH : MEMWR;
      EXEC:    state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end
  // Moore output decode; enables are collected locally and gated by reset below
  always_comb begin
    ctl.IorD     = 1'b0;
    ctl.RegDst   = 1'b0;
    ctl.MemtoReg = 1'b0;
    ctl.ALUSrcA  = 1'b0;
    ctl.ALUSrcB  = SRCB_B;
    ctl.ALUOp    = ALUOP_ADD;
    ctl.PCSrc    = PC_ALU;
    ir_w         = 1'b0;
    mem_w        = 1'b0;
    reg_w        = 1'b0;
    pc_w         = 1'b0;
    br           = 1'b0;
    case (state_q)
      FETCH: begin
        ctl.ALUSrcB = SRCB_4;
        ir_w        = done;
        pc_w        = done;
      end
      DECODE:  ctl.ALUSrcB = SRCB_IMM2;
      MEMADR: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUSrcB = SRCB_IMM;
      end
      MEMRD:   ctl.IorD = 1'b1;
      MEMWB: begin
        ctl.MemtoReg = 1'b1;
        reg_w        = 1'b1;
      end
      MEMWR: begin
        ctl.IorD = 1'b1;
        mem_w    = 1'b1;
      end
      EXEC: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUOp   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctl.RegDst = 1'b1;
        reg_w      = 1'b1;
      end
      BEQ: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUOp   = ALUOP_SUB;
        ctl.PCSrc   = PC_ALUOUT;
        br          = 1'b1;
      end
      ADDIEX: begin
        ctl.ALUSrcA = 1'b1;
        ctl.ALUSrcB = SRCB_IMM;
      end
      ADDIWB:  reg_w = 1'b1;
      JUMP: begin
        ctl.PCSrc = PC_JUMP;
        pc_w      = 1'b1;
      end
      default: ;
    endcase
  end
  assign ctl.IRWrite  = ir_w & ~reset;
  assign ctl.MemWrite = mem_w & ~reset;
  assign ctl.RegWrite = reg_w & ~reset;
  assign ctl.PCEn     = (pc_w | (br & ctl.Zero)) & ~reset;
  assign ctl.Illegal  = (state_q == DECODE) && (state_d == FETCH) && !reset;
  assign ctl.State    = STATE_W'(state_q);
endmodule
